// File: rtl/hdbn_pkg.sv
// Shared symbol encodings and polarity helpers for the HDBn line encoder.
package hdbn_pkg;

   localparam logic [1:0] SYM_ZERO = 2'b00;
   localparam logic [1:0] SYM_POS  = 2'b01;
   localparam logic [1:0] SYM_NEG  = 2'b10;

   typedef enum logic {
      POL_NEG = 1'b0,
      POL_POS = 1'b1
   } pol_t;

   function automatic pol_t pol_flip(input pol_t pol);
      return (pol == POL_POS) ? POL_NEG : POL_POS;
   endfunction

   function automatic logic [1:0] pol_to_sym(input pol_t pol);
      return (pol == POL_POS) ? SYM_POS : SYM_NEG;
   endfunction

endpackage

// File: rtl/hdbn_encoder_if.sv
// Bit-source side and line side of the HDBn encoder, grouped as one bus.
interface hdbn_encoder_if #(
   parameter int CNT_W = 16
);
   logic             i_mode;
   logic             i_valid;
   logic             i_data;
   logic             o_valid;
   logic [1:0]       o_hdb3_code;
   logic [CNT_W-1:0] o_sub_cnt;

   modport master (
      output i_mode, i_valid, i_data,
      input  o_valid, o_hdb3_code, o_sub_cnt
   );

   modport slave (
      input  i_mode, i_valid, i_data,
      output o_valid, o_hdb3_code, o_sub_cnt
   );
endinterface

// File: rtl/hdbn_delay_line.sv
// RUN-deep symbol delay line with an output register. The oldest slot can be
// rewritten on the same edge as the shift so a B pulse lands on the first
// zero of a run that is still buffered.
module hdbn_delay_line
   import hdbn_pkg::*;
#(
   parameter int RUN = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       shift_en,
   input  logic [1:0] entry_sym,
   input  logic       b_en,
   input  logic [1:0] b_sym,
   output logic [1:0] sym
);

   logic [1:0] line [RUN];

   // Shift on every accepted bit; the later B write overrides the shifted slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RUN; i++) line[i] <= SYM_ZERO;
         sym <= SYM_ZERO;
      end else if (shift_en) begin
         sym     <= line[RUN-1];
         line[0] <= entry_sym;
         for (int i = 1; i < RUN; i++) line[i] <= line[i-1];
         if (b_en) line[RUN-1] <= b_sym;
      end
   end

endmodule

// File: rtl/hdbn_encoder.sv
// HDBn / AMI line encoder: assigns polarity as bits enter the delay line and
// performs zero-run substitution (0..0V or B0..0V) on the RUN-th zero.
module hdbn_encoder
   import hdbn_pkg::*;
#(
   parameter int RUN   = 4,
   parameter int CNT_W = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   hdbn_encoder_if.slave bus
);

   localparam int            ZW     = $clog2(RUN + 1);
   localparam logic [ZW-1:0] Z_LAST = ZW'(RUN - 1);
   localparam logic [ZW-1:0] FILLED = ZW'(RUN);

   pol_t             last_pol;
   logic             par;
   logic [ZW-1:0]    zcnt;
   logic [ZW-1:0]    fill;
   logic [CNT_W-1:0] sub_cnt;
   logic             valid_q;

   logic             accept;
   logic             sub_hit;
   logic             b_hit;
   logic [1:0]       entry_sym;
   logic [1:0]       b_sym;
   logic [1:0]       code;

   // Decide the symbol entering slot 0 and whether a B rewrite is needed.
   always_comb begin
      accept    = bus.i_valid;
      sub_hit   = accept && !bus.i_data && bus.i_mode && (zcnt == Z_LAST);
      b_hit     = sub_hit && !par;
      b_sym     = pol_to_sym(pol_flip(last_pol));
      entry_sym = SYM_ZERO;
      if (accept && bus.i_data)
         entry_sym = pol_to_sym(pol_flip(last_pol));
      else if (sub_hit)
         entry_sym = par ? pol_to_sym(last_pol) : b_sym;
   end

   hdbn_delay_line #(.RUN(RUN)) u_line (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .shift_en  (accept),
      .entry_sym (entry_sym),
      .b_en      (b_hit),
      .b_sym     (b_sym),
      .sym       (code)
   );

   // Polarity, mark parity, zero-run and substitution tracking per accepted bit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_pol <= POL_NEG;
         par      <= 1'b0;
         zcnt     <= '0;
         sub_cnt  <= '0;
      end else if (accept) begin
         if (bus.i_data) begin
            last_pol <= pol_flip(last_pol);
            par      <= ~par;
            zcnt     <= '0;
         end else if (sub_hit) begin
            if (!par) last_pol <= pol_flip(last_pol);
            par  <= 1'b0;
            zcnt <= '0;
            if (sub_cnt != {CNT_W{1'b1}}) sub_cnt <= sub_cnt + 1'b1;
         end else begin
            zcnt <= (zcnt == Z_LAST) ? '0 : zcnt + 1'b1;
         end
      end
   end

   // Priming count and output qualifier: valid follows accepts once the line is full.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fill    <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= accept && (fill == FILLED);
         if (accept && (fill != FILLED)) fill <= fill + 1'b1;
      end
   end

   assign bus.o_valid     = valid_q;
   assign bus.o_hdb3_code = code;
   assign bus.o_sub_cnt   = sub_cnt;

endmodule

// File: tb/tb_hdbn_encoder.sv
// Self-checking bench for hdbn_encoder: directed scenarios plus a randomized
// stream, all checked against a whole-stream behavioural model.
module tb_hdbn_encoder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   hdbn_encoder_if #(.CNT_W(16)) bus4 ();
   hdbn_encoder_if #(.CNT_W(2))  bus3 ();

   hdbn_encoder #(.RUN(4), .CNT_W(16)) dut4 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus4.slave)
   );

   hdbn_encoder #(.RUN(3), .CNT_W(2)) dut3 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus3.slave)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [1:0] got4 [$];
   logic [1:0] got3 [$];

   // Behavioural model: the whole symbol stream as signed ints (+1, -1, 0).
   int mLastPol;
   int mPar;
   int mZcnt;
   int mSub;
   int mAcc;
   int mSyms [$];
   logic [1:0] lastCode;

   // Collect every qualified symbol away from the active edge.
   always @(negedge clk) begin
      if (bus4.o_valid === 1'b1) got4.push_back(bus4.o_hdb3_code);
      if (bus3.o_valid === 1'b1) got3.push_back(bus3.o_hdb3_code);
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [1:0] symOf(input int p);
      if (p > 0) return 2'b01;
      if (p < 0) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_reset();
      mLastPol = -1;
      mPar     = 0;
      mZcnt    = 0;
      mSub     = 0;
      mAcc     = 0;
      mSyms.delete();
      lastCode = 2'b00;
   endtask

   task automatic model_bit(input logic d, input logic m, input int run, input int maxCnt);
      mAcc++;
      if (d) begin
         mLastPol = -mLastPol;
         mSyms.push_back(mLastPol);
         mPar  = mPar ^ 1;
         mZcnt = 0;
      end else if (m && mZcnt == run - 1) begin
         if (mPar == 1) begin
            mSyms.push_back(mLastPol);
         end else begin
            mLastPol = -mLastPol;
            mSyms[mSyms.size() - (run - 1)] = mLastPol;
            mSyms.push_back(mLastPol);
         end
         mPar  = 0;
         mZcnt = 0;
         if (mSub < maxCnt) mSub++;
      end else begin
         mSyms.push_back(0);
         mZcnt = (mZcnt == run - 1) ? 0 : mZcnt + 1;
      end
   endtask

   task automatic setIdle();
      bus4.i_valid = 1'b0; bus4.i_data = 1'b0; bus4.i_mode = 1'b0;
      bus3.i_valid = 1'b0; bus3.i_data = 1'b0; bus3.i_mode = 1'b0;
   endtask

   // Drive one cycle on the chosen DUT at the falling edge and advance the model.
   task automatic applyStimulus(input int which, input logic v, input logic d,
                                input logic m, output logic expV);
      int run;
      int maxCnt;
      run    = (which == 3) ? 3 : 4;
      maxCnt = (which == 3) ? 3 : 65535;
      @(negedge clk);
      setIdle();
      if (which == 3) begin
         bus3.i_valid = v; bus3.i_data = d; bus3.i_mode = m;
      end else begin
         bus4.i_valid = v; bus4.i_data = d; bus4.i_mode = m;
      end
      expV = v && (mAcc >= run);
      if (v) model_bit(d, m, run, maxCnt);
   endtask

   task automatic hardReset();
      @(negedge clk);
      rst_n = 1'b0;
      setIdle();
      @(negedge clk);
      rst_n = 1'b1;
      got4.delete();
      got3.delete();
      model_reset();
   endtask

   task automatic test_reset();
      setIdle();
      model_reset();
      @(posedge clk);
      #1;
      compared++;
      if (bus4.o_valid !== 1'b0) begin
         mismatched++; $display("[TB] FAIL reset_valid4: got %0b expected 0", bus4.o_valid);
      end
      compared++;
      if (bus4.o_hdb3_code !== 2'b00) begin
         mismatched++; $display("[TB] FAIL reset_code4: got %0b expected 00", bus4.o_hdb3_code);
      end
      compared++;
      if (bus4.o_sub_cnt !== 16'd0) begin
         mismatched++; $display("[TB] FAIL reset_cnt4: got %0d expected 0", bus4.o_sub_cnt);
      end
      compared++;
      if (bus3.o_valid !== 1'b0) begin
         mismatched++; $display("[TB] FAIL reset_valid3: got %0b expected 0", bus3.o_valid);
      end
      compared++;
      if (bus3.o_sub_cnt !== 2'd0) begin
         mismatched++; $display("[TB] FAIL reset_cnt3: got %0d expected 0", bus3.o_sub_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_hdb3_basic();
      logic [9:0] bits = 10'b1000010000;
      logic [1:0] exp [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
      logic ev;
      hardReset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(4, 1'b1, bits[9-i], 1'b1, ev);
         if (i == 5) begin
            @(posedge clk);
            #1;
            compared++;
            if (bus4.o_sub_cnt !== 16'd1) begin
               mismatched++; $display("[TB] FAIL basic_cnt: got %0d expected 1", bus4.o_sub_cnt);
            end
         end
      end
      applyStimulus(4, 1'b0, 1'b0, 1'b0, ev);
      applyStimulus(4, 1'b0, 1'b0, 1'b0, ev);
      compared++;
      if (got4.size() !== 6) begin
         mismatched++; $display("[TB] FAIL basic_len: got %0d expected 6", got4.size());
      end
      for (int i = 0; i < 6 && i < got4.size(); i++) begin
         compared++;
         if (got4[i] !== exp[i]) begin
            mismatched++; $display("[TB] FAIL basic_sym[%0d]: got %b expected %b", i, got4[i], exp[i]);
         end
      end
      compared++;
      if (bus4.o_sub_cnt !== 16'(mSub)) begin
         mismatched++; $display("[TB] FAIL basic_cnt_end: got %0d expected %0d", bus4.o_sub_cnt, mSub);
      end
   endtask

   task automatic test_all_zeros();
      logic [1:0] exp [8] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10};
      logic ev;
      hardReset();
      for (int i = 0; i < 8; i++) applyStimulus(4, 1'b1, 1'b0, 1'b1, ev);
      for (int i = 0; i < 4; i++) applyStimulus(4, 1'b1, 1'b0, 1'b0, ev);
      applyStimulus(4, 1'b0, 1'b0, 1'b0, ev);
      applyStimulus(4, 1'b0, 1'b0, 1'b0, ev);
      compared++;
      if (got4.size() !== 8) begin
         mismatched++; $display("[TB] FAIL zeros_len: got %0d expected 8", got4.size());
      end
      for (int i = 0; i < 8 && i < got4.size(); i++) begin
         compared++;
         if (got4[i] !== exp[i]) begin
            mismatched++; $display("[TB] FAIL zeros_sym[%0d]: got %b expected %b", i, got4[i], exp[i]);
         end
      end
      compared++;
      if (bus4.o_sub_cnt !== 16'd2) begin
         mismatched++; $display("[TB] FAIL zeros_cnt: got %0d expected 2", bus4.o_sub_cnt);
      end
   endtask

   task automatic test_ami();
      logic [9:0] bits = 10'b1000010000;
      logic [1:0] exp [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
      logic ev;
      hardReset();
      for (int i = 0; i < 10; i++) applyStimulus(4, 1'b1, bits[9-i], 1'b0, ev);
      applyStimulus(4, 1'b0, 1'b0, 1'b0, ev);
      applyStimulus(4, 1'b0, 1'b0, 1'b0, ev);
      compared++;
      if (got4.size() !== 6) begin
         mismatched++; $display("[TB] FAIL ami_len: got %0d expected 6", got4.size());
      end
      for (int i = 0; i < 6 && i < got4.size(); i++) begin
         compared++;
         if (got4[i] !== exp[i]) begin
            mismatched++; $display("[TB] FAIL ami_sym[%0d]: got %b expected %b", i, got4[i], exp[i]);
         end
      end
      compared++;
      if (bus4.o_sub_cnt !== 16'd0) begin
         mismatched++; $display("[TB] FAIL ami_cnt: got %0d expected 0", bus4.o_sub_cnt);
      end
   endtask

   task automatic test_stall();
      logic [1:0] exp [8] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10};
      logic ev;
      logic m;
      hardReset();
      for (int i = 0; i < 12; i++) begin
         m = (i < 8);
         for (int g = 0; g < 3; g++) begin
            applyStimulus(4, (g == 0), 1'b0, m, ev);
            @(posedge clk);
            #1;
            compared++;
            if (bus4.o_valid !== ev) begin
               mismatched++; $display("[TB] FAIL stall_valid[%0d.%0d]: got %b expected %b", i, g, bus4.o_valid, ev);
            end
            if (ev) lastCode = symOf(mSyms[mAcc-1-4]);
            compared++;
            if (bus4.o_hdb3_code !== lastCode) begin
               mismatched++; $display("[TB] FAIL stall_code[%0d.%0d]: got %b expected %b", i, g, bus4.o_hdb3_code, lastCode);
            end
         end
      end
      applyStimulus(4, 1'b0, 1'b0, 1'b0, ev);
      compared++;
      if (got4.size() !== 8) begin
         mismatched++; $display("[TB] FAIL stall_len: got %0d expected 8", got4.size());
      end
      for (int i = 0; i < 8 && i < got4.size(); i++) begin
         compared++;
         if (got4[i] !== exp[i]) begin
            mismatched++; $display("[TB] FAIL stall_sym[%0d]: got %b expected %b", i, got4[i], exp[i]);
         end
      end
      compared++;
      if (bus4.o_sub_cnt !== 16'd2) begin
         mismatched++; $display("[TB] FAIL stall_cnt: got %0d expected 2", bus4.o_sub_cnt);
      end
   endtask

   task automatic test_reset_midstream();
      logic [5:0] bits = 6'b100001;
      logic ev;
      int n;
      hardReset();
      for (int i = 0; i < 6; i++) applyStimulus(4, 1'b1, bits[5-i], 1'b1, ev);
      @(negedge clk);
      setIdle();
      rst_n = 1'b0;
      #1;
      compared++;
      if (bus4.o_valid !== 1'b0) begin
         mismatched++; $display("[TB] FAIL midrst_valid: got %b expected 0", bus4.o_valid);
      end
      compared++;
      if (bus4.o_hdb3_code !== 2'b00) begin
         mismatched++; $display("[TB] FAIL midrst_code: got %b expected 00", bus4.o_hdb3_code);
      end
      compared++;
      if (bus4.o_sub_cnt !== 16'd0) begin
         mismatched++; $display("[TB] FAIL midrst_cnt: got %0d expected 0", bus4.o_sub_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      got4.delete();
      model_reset();
      for (int i = 0; i < 5; i++) applyStimulus(4, 1'b1, (i == 0), 1'b1, ev);
      for (int i = 0; i < 4; i++) applyStimulus(4, 1'b1, 1'b0, 1'b0, ev);
      applyStimulus(4, 1'b0, 1'b0, 1'b0, ev);
      applyStimulus(4, 1'b0, 1'b0, 1'b0, ev);
      compared++;
      if (got4.size() < 1 || got4[0] !== 2'b01) begin
         mismatched++; $display("[TB] FAIL midrst_first: got %b expected 01", (got4.size() > 0) ? got4[0] : 2'bxx);
      end
      n = mAcc - 4;
      compared++;
      if (got4.size() !== n) begin
         mismatched++; $display("[TB] FAIL midrst_len: got %0d expected %0d", got4.size(), n);
      end
      for (int i = 0; i < n && i < got4.size(); i++) begin
         compared++;
         if (got4[i] !== symOf(mSyms[i])) begin
            mismatched++; $display("[TB] FAIL midrst_sym[%0d]: got %b expected %b", i, got4[i], symOf(mSyms[i]));
         end
      end
   endtask

   task automatic test_run3_saturate();
      logic ev;
      logic [1:0] expSym;
      hardReset();
      for (int i = 0; i < 24; i++) begin
         applyStimulus(3, 1'b1, 1'b0, 1'b1, ev);
         if (i == 5) begin
            @(posedge clk);
            #1;
            compared++;
            if (bus3.o_sub_cnt !== 2'd2) begin
               mismatched++; $display("[TB] FAIL run3_cnt_mid: got %0d expected 2", bus3.o_sub_cnt);
            end
         end
      end
      for (int i = 0; i < 3; i++) applyStimulus(3, 1'b1, 1'b0, 1'b0, ev);
      applyStimulus(3, 1'b0, 1'b0, 1'b0, ev);
      applyStimulus(3, 1'b0, 1'b0, 1'b0, ev);
      compared++;
      if (got3.size() !== 24) begin
         mismatched++; $display("[TB] FAIL run3_len: got %0d expected 24", got3.size());
      end
      for (int i = 0; i < 24 && i < got3.size(); i++) begin
         if ((i % 3) == 1) expSym = 2'b00;
         else expSym = (((i / 3) % 2) == 0) ? 2'b01 : 2'b10;
         compared++;
         if (got3[i] !== expSym) begin
            mismatched++; $display("[TB] FAIL run3_sym[%0d]: got %b expected %b", i, got3[i], expSym);
         end
      end
      compared++;
      if (bus3.o_sub_cnt !== 2'd3) begin
         mismatched++; $display("[TB] FAIL run3_cnt_sat: got %0d expected 3", bus3.o_sub_cnt);
      end
   endtask

   task automatic test_random();
      logic ev;
      logic v;
      logic d;
      logic m;
      int n;
      hardReset();
      m = 1'b1;
      for (int c = 0; c < 400; c++) begin
         v = ($urandom_range(0, 9) < 7);
         d = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 19) == 0) m = ~m;
         applyStimulus(4, v, d, m, ev);
         @(posedge clk);
         #1;
         compared++;
         if (bus4.o_valid !== ev) begin
            mismatched++; $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", c, bus4.o_valid, ev);
         end
         if (ev) lastCode = symOf(mSyms[mAcc-1-4]);
         compared++;
         if (bus4.o_hdb3_code !== lastCode) begin
            mismatched++; $display("[TB] FAIL rand_code[%0d]: got %b expected %b", c, bus4.o_hdb3_code, lastCode);
         end
      end
      applyStimulus(4, 1'b0, 1'b0, 1'b0, ev);
      applyStimulus(4, 1'b0, 1'b0, 1'b0, ev);
      n = (mAcc > 4) ? mAcc - 4 : 0;
      compared++;
      if (got4.size() !== n) begin
         mismatched++; $display("[TB] FAIL rand_len: got %0d expected %0d", got4.size(), n);
      end
      for (int i = 0; i < n && i < got4.size(); i++) begin
         compared++;
         if (got4[i] !== symOf(mSyms[i])) begin
            mismatched++; $display("[TB] FAIL rand_sym[%0d]: got %b expected %b", i, got4[i], symOf(mSyms[i]));
         end
      end
      compared++;
      if (bus4.o_sub_cnt !== 16'(mSub)) begin
         mismatched++; $display("[TB] FAIL rand_cnt: got %0d expected %0d", bus4.o_sub_cnt, mSub);
      end
   endtask

   initial begin
      test_reset();
      test_hdb3_basic();
      test_all_zeros();
      test_ami();
      test_stall();
      test_reset_midstream();
      test_run3_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hdbn_encoder.md
# hdbn_encoder

Parametrised HDBn line encoder, successor to the fixed HDB3 coder. Converts a unipolar bit stream into a ternary AMI/HDBn symbol stream with a configurable zero-run limit, a runtime AMI/HDBn mode select and a stall-tolerant valid qualifier. It also provides a saturating substitution counter. It sits between the bit source (pulse/PRBS generator) and the line interface or matching decoder.

## Interface
- RUN, default 4: zero-run length that triggers substitution (4 = HDB3, 3 = HDB2); legal range 2..8.
- CNT_W, default 16: width of the substitution counter.
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- i_mode  in  1  0 = plain AMI, 1 = HDBn substitution; sampled on every accepted bit.
- i_valid  in  1  i_data accepted on rising edge when high; no backpressure.
- i_data  in  1  unipolar input bit.
- o_valid  out  1  o_hdb3_code holds a new symbol this cycle.
- o_hdb3_code  out  2  symbol: 2'b00 zero, 2'b01 positive pulse, 2'b10 negative pulse; 2'b11 never emitted.
- o_sub_cnt  out  CNT_W  count of substitutions performed, saturating.

## Operation
- Pipeline advances only on accepted bits (i_valid=1); idle cycles freeze all state.
- The pipeline is a RUN-deep symbol delay line. Polarity is assigned at entry.
- Each accepted bit enters slot 0. The oldest slot (RUN-1) shifts into the output register.
- Tracking state:
  - last_pol: polarity of last pulse, B or V included; reset = negative, so the first mark is positive.
  - par: number of marks since last V, mod 2; reset 0.
  - zcnt: consecutive zeros, 0..RUN-1; reset 0.
- Mark (i_data=1):
  - Entry symbol = opposite of last_pol.
  - last_pol toggles, par toggles, zcnt clears.
- Zero, mode 1, zcnt = RUN-1 (RUN-th zero):
  - par = 1: slot 0 becomes V with polarity last_pol. last_pol is unchanged. Pattern 0..0V.
  - par = 0: slot RUN-1 (the first zero of the run, still in the line) becomes B with polarity ~last_pol. Slot 0 becomes V with the same polarity. last_pol becomes ~last_pol. Pattern B0..0V.
  - Both cases: par clears, zcnt clears, o_sub_cnt increments (holds at all-ones).
- Zero otherwise: enters as 2'b00; zcnt increments, wrapping to 0 after the RUN-th zero. In mode 0 zcnt still counts but no substitution occurs.
- Mode switching mid-stream is legal. The decision uses i_mode at the RUN-th zero. last_pol and par persist across modes.
- Priming: the first RUN accepted bits after reset fill the line and produce no o_valid.

## Timing
- Reset values: o_valid 0, o_hdb3_code 2'b00, o_sub_cnt 0, delay line all 2'b00, last_pol negative, par 0, zcnt 0.
- Latency: the symbol for accepted bit k is registered on the edge accepting bit k+RUN. o_valid is high for exactly the following cycle.
- o_hdb3_code holds its last value while o_valid=0.
- The substitution rewrite and the shift happen on the same edge. B is written into the slot position after the shift.
- Reset assertion mid-stream discards all buffered symbols immediately; no partial substitution is emitted.

## Structure
- Package hdbn_pkg holds:
  - symbol constants SYM_ZERO, SYM_POS, SYM_NEG;
  - function pol_to_sym(pol).
- One sub-module, hdbn_delay_line. It holds the RUN-deep 2-bit shift register with a shift enable, a slot-0 write, a slot-(RUN-1) overwrite port and the output register.
- Polarity, parity, zero counter and substitution counter live in hdbn_encoder.

## Test plan
- RUN=4, mode 1, continuous valid, bits 1 0 0 0 0 1 then four padding zeros -> symbols 01 00 00 00 01 10 (+000V with V=+, then -); o_sub_cnt=1.
- RUN=4, mode 1, eight zeros from reset -> 01 00 00 01 10 00 00 10 (+00+ -00-); o_sub_cnt=2.
- RUN=4, mode 0, bits 1 0 0 0 0 1 -> 01 00 00 00 00 10; o_sub_cnt=0.
- RUN=4, mode 1, same stream as the second test with i_valid toggled 1,0,0,1,... -> identical symbol sequence; o_valid only in the cycle after qualifying accepts; state frozen during gaps.
- Reset pulse after 6 accepted bits -> outputs 00, o_valid 0, o_sub_cnt 0 within the reset cycle; next stream 1 0 0 0 0 -> first mark 01 again.
- RUN=3, CNT_W=2, 24 zeros -> alternating +0+ -0- groups; o_sub_cnt saturates at 3.
